// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle sequencer: FSM state encoding,
// instruction op classes, the opcode constants recognised by the datapath
// and a helper that maps an opcode onto its op class.
package mc_pkg;

  // State encoding is exported on the debug port, so the values are fixed.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_NOP   = 3'd0,
    C_ALU   = 3'd1,
    C_SWAP  = 3'd2,
    C_LOAD  = 3'd3,
    C_STORE = 3'd4,
    C_BR    = 3'd5,
    C_JMP   = 3'd6
  } opclass_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_SWAP = 7'b1010100;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_LWI  = 7'b0000111;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_SS   = 7'b0100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JMP  = 7'b1101111;

  // Anything not recognised, including an all-zero word, is treated as a NOP
  // so that garbage in the instruction register simply advances the PC.
  function automatic opclass_t decode_op(input logic [6:0] op);
    opclass_t cls;
    case (op)
      OP_R, OP_IMM, OP_LUI: cls = C_ALU;
      OP_SWAP:              cls = C_SWAP;
      OP_LW, OP_LWI:        cls = C_LOAD;
      OP_SW, OP_SS:         cls = C_STORE;
      OP_BR:                cls = C_BR;
      OP_JMP:               cls = C_JMP;
      default:              cls = C_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive requested-but-unacknowledged memory cycles and flags
// the cycle in which the TIMEOUT-th such cycle also goes unacknowledged.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   clr     - hold the count at zero (asserted while no access is pending)
//   req     - memory request active this cycle
//   ack     - memory acknowledge this cycle
//   expired - combinational: this is the TIMEOUT-th un-acked request cycle
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // The count holds the number of un-acked cycles already seen, so the
  // final allowed cycle is the one where it equals TIMEOUT-1. An ack in
  // that cycle still wins; only an un-acked final cycle expires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr || (req && ack)) begin
      r_count <= '0;
    end else if (req && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = req && !ack && (r_count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the RV32-subset datapath. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, shares one memory port between
// instruction and data accesses, traps stalled accesses into a sticky FAULT
// state, counts retired instructions and stops at instruction boundaries
// when halt is requested.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   opcode        - inst[6:0] from the instruction register
//   halt          - stop at the next instruction boundary
//   mem_ack       - memory completion (may coincide with mem_req)
//   takebranch    - ALU branch outcome, valid in EXEC
//   ir_we, pc_we  - instruction register / PC load strobes
//   pc_src        - 0: PC+4, 1: branch/jump target
//   reg_we(2)     - register-file write ports (second one for swap)
//   mem_req/sel/we- shared memory port request, address select, write
//   busy, fault   - activity and sticky timeout status
//   state         - current state encoding for debug
//   instret       - retired-instruction counter
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             halt,
  input  logic             mem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  input  logic             takebranch,
  output logic             reg_we,
  output logic             reg_we2,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  opclass_t         r_class;
  logic [CNT_W-1:0] r_instret;

  state_t w_next;
  logic   w_retire;
  logic   w_irWe, w_pcWe, w_pcSrc, w_regWe, w_regWe2;
  logic   w_memReq, w_memSel, w_memWe;
  logic   w_expired;
  logic   w_timerClr;

  // The wait counter is held clear whenever no access is in flight, which
  // guarantees it starts from zero on every entry to FETCH or MEM.
  assign w_timerClr = (r_state != S_FETCH) && (r_state != S_MEM);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_timerClr),
    .req     (w_memReq),
    .ack     (mem_ack),
    .expired (w_expired)
  );

  // Strobes are decoded from the registered state and op class plus the
  // live ack/branch inputs, so they drop to zero the instant reset forces
  // the state back to IDLE.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_irWe   = 1'b0;
    w_pcWe   = 1'b0;
    w_pcSrc  = 1'b0;
    w_regWe  = 1'b0;
    w_regWe2 = 1'b0;
    w_memReq = 1'b0;
    w_memSel = 1'b0;
    w_memWe  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!halt) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_memReq = 1'b1;
        if (mem_ack) begin
          w_irWe = 1'b1;
          w_next = S_DECODE;
        end else if (w_expired) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_next = S_EXEC;
      end
      S_EXEC: begin
        case (r_class)
          C_BR: begin
            w_pcWe   = 1'b1;
            w_pcSrc  = takebranch;
            w_retire = 1'b1;
          end
          C_JMP: begin
            w_pcWe   = 1'b1;
            w_pcSrc  = 1'b1;
            w_retire = 1'b1;
          end
          C_ALU, C_SWAP:   w_next = S_WB;
          C_LOAD, C_STORE: w_next = S_MEM;
          default: begin
            w_pcWe   = 1'b1;
            w_retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        w_memReq = 1'b1;
        w_memSel = 1'b1;
        w_memWe  = (r_class == C_STORE);
        if (mem_ack) begin
          if (r_class == C_STORE) begin
            w_pcWe   = 1'b1;
            w_retire = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end else if (w_expired) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_regWe  = 1'b1;
        w_regWe2 = (r_class == C_SWAP);
        w_pcWe   = 1'b1;
        w_retire = 1'b1;
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Every retiring path funnels through here so halt is honoured only at
    // instruction boundaries.
    if (w_retire) w_next = halt ? S_IDLE : S_FETCH;
  end

  // State, latched op class and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_class   <= C_NOP;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_class <= decode_op(opcode);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign ir_we   = w_irWe;
  assign pc_we   = w_pcWe;
  assign pc_src  = w_pcSrc;
  assign reg_we  = w_regWe;
  assign reg_we2 = w_regWe2;
  assign mem_req = w_memReq;
  assign mem_sel = w_memSel;
  assign mem_we  = w_memWe;
  assign busy    = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign fault   = (r_state == S_FAULT);
  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. Instruction sequences are expanded into a
// queue of per-cycle stimulus plus the expected state/strobe vector and
// retire count; the driver pops one entry per clock and compares.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             halt;
  logic             mem_ack;
  logic             takebranch;
  logic             ir_we, pc_we, pc_src, reg_we, reg_we2;
  logic             mem_req, mem_sel, mem_we, busy, fault;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .halt       (halt),
    .mem_ack    (mem_ack),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .takebranch (takebranch),
    .reg_we     (reg_we),
    .reg_we2    (reg_we2),
    .mem_req    (mem_req),
    .mem_sel    (mem_sel),
    .mem_we     (mem_we),
    .busy       (busy),
    .fault      (fault),
    .state      (state),
    .instret    (instret)
  );

  typedef struct {
    logic [6:0]  opc;
    logic        ack;
    logic        hlt;
    logic        tb;
    logic [12:0] expVec;
    logic [31:0] expCnt;
  } cycle_t;

  cycle_t      q[$];
  int          checks = 0;
  int          failures = 0;
  int          cycleNo = 0;
  logic [31:0] expCount = '0;

  // Expected output vector: {state, ir_we, pc_we, pc_src, reg_we, reg_we2,
  // mem_req, mem_sel, mem_we, busy, fault}.
  function automatic logic [12:0] mkVec(input logic [2:0] st,
                                        input logic ir, input logic pw,
                                        input logic ps, input logic rw,
                                        input logic rw2, input logic rq,
                                        input logic sl, input logic we);
    logic bsy, flt;
    bsy = (st != 3'(S_IDLE)) && (st != 3'(S_FAULT));
    flt = (st == 3'(S_FAULT));
    return {st, ir, pw, ps, rw, rw2, rq, sl, we, bsy, flt};
  endfunction

  // Independent classification of the opcode table: 0 ALU, 1 SWAP,
  // 2 LOAD, 3 STORE, 4 BR, 5 JMP, 6 NOP.
  function automatic int benchClass(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111: return 0;
      7'b1010100:                         return 1;
      7'b0000011, 7'b0000111:             return 2;
      7'b0100011, 7'b0100111:             return 3;
      7'b1100011:                         return 4;
      7'b1101111:                         return 5;
      default:                            return 6;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushCycle(input logic [6:0] opc, input logic a,
                           input logic h, input logic t,
                           input logic [12:0] v, input bit retire);
    cycle_t c;
    c.opc    = opc;
    c.ack    = a;
    c.hlt    = h;
    c.tb     = t;
    c.expVec = v;
    c.expCnt = expCount;
    q.push_back(c);
    if (retire) expCount = expCount + 32'd1;
  endtask

  // Expands one instruction, starting in FETCH, into expected cycles.
  // DECODE drives halt=haltRet and non-memory cycles drive ack=1 so that
  // ignored inputs are exercised too.
  task automatic runInstr(input logic [6:0] opc, input int fWait,
                          input int mWait, input logic tbv,
                          input logic haltRet);
    int cls;
    cls = benchClass(opc);
    for (int i = 0; i < fWait; i++)
      pushCycle(opc, 1'b0, 1'b0, tbv,
                mkVec(3'(S_FETCH), 0, 0, 0, 0, 0, 1, 0, 0), 0);
    pushCycle(opc, 1'b1, 1'b0, tbv,
              mkVec(3'(S_FETCH), 1, 0, 0, 0, 0, 1, 0, 0), 0);
    pushCycle(opc, 1'b1, haltRet, tbv,
              mkVec(3'(S_DECODE), 0, 0, 0, 0, 0, 0, 0, 0), 0);
    case (cls)
      4: pushCycle(opc, 1'b1, haltRet, tbv,
                   mkVec(3'(S_EXEC), 0, 1, tbv, 0, 0, 0, 0, 0), 1);
      5: pushCycle(opc, 1'b1, haltRet, tbv,
                   mkVec(3'(S_EXEC), 0, 1, 1, 0, 0, 0, 0, 0), 1);
      6: pushCycle(opc, 1'b1, haltRet, tbv,
                   mkVec(3'(S_EXEC), 0, 1, 0, 0, 0, 0, 0, 0), 1);
      default: begin
        pushCycle(opc, 1'b1, 1'b0, tbv,
                  mkVec(3'(S_EXEC), 0, 0, 0, 0, 0, 0, 0, 0), 0);
        if (cls == 2 || cls == 3) begin
          for (int i = 0; i < mWait; i++)
            pushCycle(opc, 1'b0, 1'b0, tbv,
                      mkVec(3'(S_MEM), 0, 0, 0, 0, 0, 1, 1, cls == 3), 0);
        end
        if (cls == 3) begin
          pushCycle(opc, 1'b1, haltRet, tbv,
                    mkVec(3'(S_MEM), 0, 1, 0, 0, 0, 1, 1, 1), 1);
        end else begin
          if (cls == 2)
            pushCycle(opc, 1'b1, 1'b0, tbv,
                      mkVec(3'(S_MEM), 0, 0, 0, 0, 0, 1, 1, 0), 0);
          pushCycle(opc, 1'b1, haltRet, tbv,
                    mkVec(3'(S_WB), 0, 1, 0, 1, cls == 1, 0, 0, 0), 1);
        end
      end
    endcase
    if (haltRet) begin
      pushCycle(opc, 1'b1, 1'b1, 1'b0,
                mkVec(3'(S_IDLE), 0, 0, 0, 0, 0, 0, 0, 0), 0);
      pushCycle(opc, 1'b1, 1'b0, 1'b0,
                mkVec(3'(S_IDLE), 0, 0, 0, 0, 0, 0, 0, 0), 0);
    end
  endtask

  // Drains the queue: one entry per clock, inputs driven on the falling
  // edge and outputs sampled 1 time unit later.
  task automatic applyStimulus();
    cycle_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      opcode     = c.opc;
      mem_ack    = c.ack;
      halt       = c.hlt;
      takebranch = c.tb;
      #1;
      checkOutput($sformatf("c%0d_vec", cycleNo),
                  {state, ir_we, pc_we, pc_src, reg_we, reg_we2,
                   mem_req, mem_sel, mem_we, busy, fault}, c.expVec);
      checkOutput($sformatf("c%0d_instret", cycleNo), instret, c.expCnt);
      cycleNo++;
    end
  endtask

  // Asserts reset between clock edges and checks the outputs respond
  // without waiting for a clock edge.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("reset_vec",
                {state, ir_we, pc_we, pc_src, reg_we, reg_we2,
                 mem_req, mem_sel, mem_we, busy, fault},
                mkVec(3'(S_IDLE), 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("reset_instret", instret, 32'd0);
    halt = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    expCount = '0;
  endtask

  initial begin
    rst        = 1'b0;
    opcode     = 7'd0;
    halt       = 1'b1;
    mem_ack    = 1'b0;
    takebranch = 1'b0;
    #2;
    doReset();

    pushCycle(7'd0, 1'b1, 1'b0, 1'b0,
              mkVec(3'(S_IDLE), 0, 0, 0, 0, 0, 0, 0, 0), 0);
    runInstr(OP_R,    0, 0, 1'b0, 1'b0);
    runInstr(OP_LW,   0, 3, 1'b0, 1'b0);
    runInstr(OP_BR,   0, 0, 1'b1, 1'b0);
    runInstr(OP_BR,   0, 0, 1'b0, 1'b0);
    runInstr(OP_SWAP, 0, 0, 1'b0, 1'b0);
    runInstr(OP_SW,   0, 1, 1'b0, 1'b0);
    runInstr(OP_JMP,  1, 0, 1'b0, 1'b0);
    runInstr(7'h00,   0, 0, 1'b1, 1'b0);
    runInstr(OP_LUI,  2, 0, 1'b0, 1'b0);
    runInstr(OP_IMM,  0, 0, 1'b0, 1'b1);
    runInstr(OP_SS,   0, 0, 1'b0, 1'b1);
    runInstr(OP_LWI, TIMEOUT - 1, TIMEOUT - 1, 1'b0, 1'b0);
    runInstr(7'h7f,   0, 0, 1'b0, 1'b0);
    applyStimulus();

    // Reset in the middle of a stalled load.
    pushCycle(OP_LW, 1'b1, 1'b0, 1'b0,
              mkVec(3'(S_FETCH), 1, 0, 0, 0, 0, 1, 0, 0), 0);
    pushCycle(OP_LW, 1'b1, 1'b0, 1'b0,
              mkVec(3'(S_DECODE), 0, 0, 0, 0, 0, 0, 0, 0), 0);
    pushCycle(OP_LW, 1'b1, 1'b0, 1'b0,
              mkVec(3'(S_EXEC), 0, 0, 0, 0, 0, 0, 0, 0), 0);
    pushCycle(OP_LW, 1'b0, 1'b0, 1'b0,
              mkVec(3'(S_MEM), 0, 0, 0, 0, 0, 1, 1, 0), 0);
    pushCycle(OP_LW, 1'b0, 1'b0, 1'b0,
              mkVec(3'(S_MEM), 0, 0, 0, 0, 0, 1, 1, 0), 0);
    applyStimulus();
    #2;
    doReset();

    // Fetch that is never acknowledged runs into FAULT; acks are then ignored.
    pushCycle(OP_R, 1'b0, 1'b0, 1'b0,
              mkVec(3'(S_IDLE), 0, 0, 0, 0, 0, 0, 0, 0), 0);
    for (int i = 0; i < TIMEOUT; i++)
      pushCycle(OP_R, 1'b0, 1'b0, 1'b0,
                mkVec(3'(S_FETCH), 0, 0, 0, 0, 0, 1, 0, 0), 0);
    for (int i = 0; i < 3; i++)
      pushCycle(OP_R, 1'b1, 1'b0, 1'b0,
                mkVec(3'(S_FAULT), 0, 0, 0, 0, 0, 0, 0, 0), 0);
    applyStimulus();
    #2;
    doReset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
